// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: registered N-to-log2(N) request encoder with
// fixed-priority or round-robin resolution and a valid/ready handshake.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   in_valid/in_ready  request-side handshake
//   req                request vector, N bits
//   out_valid/ready    result-side handshake
//   out_idx            index of the winning request bit
//   out_none           accepted req was all zeros (idx forced to 0)
//   out_multi          accepted req had two or more bits set
module priority_encoder_rr #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_multi
);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] start;
  logic [W-1:0] win;
  logic         found;
  logic         multi;
  logic         accept;

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         none_q, none_d;
  logic         multi_q, multi_d;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Fixed priority is round-robin with the search pinned to bit 0.
  assign start = (MODE == 1) ? ptr_q : '0;

  // Clearing the lowest set bit leaves something only if 2+ were set.
  assign multi = |(req & (req - 1'b1));

  // Rotating search; wrap happens at N, so ptr never leaves 0..N-1.
  always_comb begin
    int j;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[W'(j)]) begin
        found = 1'b1;
        win   = W'(j);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    none_d  = none_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (accept) begin
      valid_d = 1'b1;
      idx_d   = win;
      none_d  = !found;
      multi_d = multi;
      if ((MODE == 1) && found) begin
        ptr_d = (win == W'(N - 1)) ? '0 : win + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      none_q  <= none_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_none  = none_q;
  assign out_multi = multi_q;

endmodule
